otsu_thresh: RTL and testbench

- Consumer of the per-threshold class statistics stream produced by the histogram block in the canny/otus path.
- For each candidate threshold t (0..127) it computes the Otsu between-class variance N1·N2·(m1−m2)², where m1 = GrayAll1/N1 and m2 = GrayAll2/N2.
- It tracks the maximum over the frame and emits the winning threshold when the histogram block signals end of frame (finish_clear).
- The result feeds the canny high/low threshold logic.

---
 rtl/otsu_pkg.sv | 19 +
 rtl/otsu_div.sv | 52 +++++
 rtl/otsu_thresh.sv | 138 +++++++++++++
 tb/tb_otsu_thresh.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/otsu_pkg.sv
// Shared widths and FSM encoding for the Otsu threshold search.
package otsu_pkg;
  localparam int GW     = 7;
  localparam int NW     = 20;
  localparam int SW     = 23;
  localparam int PW     = 2 * NW;
  localparam int VW     = 2 * NW + 2 * GW;
  localparam int DIVLAT = 8;

  typedef enum logic [2:0] {
    IDLE,
    DIV1,
    DIV2,
    MUL1,
    MUL2,
    CMP,
    OUT
  } state_t;
endpackage

// File: rtl/otsu_div.sv
// Restoring divider: GW-bit quotient, one bit per cycle MSB-first, done DIVLAT cycles after start.
module otsu_div
  import otsu_pkg::*;
(
  input  logic          clock,
  input  logic          rst,
  input  logic          start,
  input  logic [SW-1:0] dividend,
  input  logic [NW-1:0] divisor,
  output logic [GW-1:0] quotient,
  output logic          done
);
  localparam int XW = SW + GW;

  logic [2:0]    cnt;
  logic [SW-1:0] rem;
  logic [NW-1:0] dvs;
  logic [XW-1:0] dsh;
  logic          q_bit;

  // cnt counts the quotient bits still to resolve; bit index is cnt-1
  always_comb begin
    dsh   = XW'(dvs) << (cnt - 3'd1);
    q_bit = (XW'(rem) >= dsh);
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        cnt <= 3'(DIVLAT - 1);
      end else if (cnt != 3'd0) begin
        cnt  <= cnt - 3'd1;
        done <= (cnt == 3'd1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (start) begin
      rem      <= dividend;
      dvs      <= divisor;
      quotient <= '0;
    end else if (cnt != 3'd0) begin
      quotient <= {quotient[GW-2:0], q_bit};
      if (q_bit) rem <= rem - dsh[SW-1:0];
    end
  end
endmodule

// File: rtl/otsu_thresh.sv
// Otsu threshold search: evaluates N1*N2*(m1-m2)^2 per candidate and reports the frame maximum.
module otsu_thresh
  import otsu_pkg::*;
(
  input  logic          clock,
  input  logic          rst,
  input  logic          dsp_vld,
  input  logic [NW-1:0] N1,
  input  logic [NW-1:0] N2,
  input  logic [SW-1:0] GrayAll1,
  input  logic [SW-1:0] GrayAll2,
  input  logic          finish_clear,
  output logic [GW-1:0] thresh,
  output logic          thresh_vld,
  output logic          busy,
  output logic          ovr
);
  state_t state, state_nxt;

  logic [GW-1:0]   t_cnt, cur_t, best_t;
  logic [VW-1:0]   best_var;
  logic            pend;
  logic [NW-1:0]   n1_p0, n2_p0;
  logic [SW-1:0]   g2_p0;
  logic            zero_p0;
  logic [GW-1:0]   m1_p0, m2_p0, d;
  logic [2*GW-1:0] d2_p1;
  logic [PW-1:0]   prod_p1;
  logic [VW-1:0]   var_p2;
  logic            in_zero;
  logic            div_start, div_done;
  logic [SW-1:0]   div_dividend;
  logic [NW-1:0]   div_divisor;
  logic [GW-1:0]   div_q;

  assign in_zero = (N1 == '0) || (N2 == '0);
  assign busy    = (state != IDLE);
  assign ovr     = dsp_vld && busy && !rst;

  otsu_div u_div (
    .clock    (clock),
    .rst      (rst),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .quotient (div_q),
    .done     (div_done)
  );

  // The divider reads the live inputs in IDLE for m1, then the captured class-2 operands for m2
  always_comb begin
    state_nxt    = state;
    div_start    = 1'b0;
    div_dividend = GrayAll1;
    div_divisor  = N1;
    case (state)
      IDLE: begin
        if (dsp_vld) begin
          if (in_zero) begin
            state_nxt = MUL1;
          end else begin
            state_nxt = DIV1;
            div_start = 1'b1;
          end
        end else if (finish_clear || pend) begin
          state_nxt = OUT;
        end
      end
      DIV1: begin
        div_dividend = g2_p0;
        div_divisor  = n2_p0;
        if (div_done) begin
          state_nxt = DIV2;
          div_start = 1'b1;
        end
      end
      DIV2:    if (div_done) state_nxt = MUL1;
      MUL1:    state_nxt = MUL2;
      MUL2:    state_nxt = CMP;
      CMP:     state_nxt = pend ? OUT : IDLE;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state      <= IDLE;
      t_cnt      <= '0;
      pend       <= 1'b0;
      best_var   <= '0;
      best_t     <= '0;
      thresh     <= '0;
      thresh_vld <= 1'b0;
    end else begin
      state      <= state_nxt;
      thresh_vld <= 1'b0;
      if (state == OUT) begin
        thresh     <= best_t;
        thresh_vld <= 1'b1;
        t_cnt      <= '0;
        pend       <= 1'b0;
        best_var   <= '0;
        best_t     <= '0;
      end else begin
        if (dsp_vld) t_cnt <= t_cnt + GW'(1);
        if (finish_clear && (busy || dsp_vld)) pend <= 1'b1;
        // strict compare keeps the lowest t on ties
        if (state == CMP && var_p2 > best_var) begin
          best_var <= var_p2;
          best_t   <= cur_t;
        end
      end
    end
  end

  always_comb d = (m2_p0 >= m1_p0) ? (m2_p0 - m1_p0) : (m1_p0 - m2_p0);

  always_ff @(posedge clock) begin
    // p0: candidate capture and class means
    if (state == IDLE && dsp_vld) begin
      n1_p0   <= N1;
      n2_p0   <= N2;
      g2_p0   <= GrayAll2;
      zero_p0 <= in_zero;
      cur_t   <= t_cnt;
    end
    if (state == DIV1 && div_done) m1_p0 <= div_q;
    if (state == DIV2 && div_done) m2_p0 <= div_q;
    // p1: squared mean distance and class-count product
    if (state == MUL1) begin
      d2_p1   <= zero_p0 ? '0 : (2*GW)'(d) * (2*GW)'(d);
      prod_p1 <= PW'(n1_p0) * PW'(n2_p0);
    end
    // p2: between-class variance
    if (state == MUL2) var_p2 <= VW'(prod_p1) * VW'(d2_p1);
  end
endmodule

// File: tb/tb_otsu_thresh.sv
// Directed bench for otsu_thresh: histogram frames, overrun, early end and mid-run reset.
module tb_otsu_thresh;
  import otsu_pkg::*;

  logic          clock = 1'b0;
  logic          rst = 1'b1;
  logic          dsp_vld = 1'b0;
  logic [NW-1:0] N1 = '0, N2 = '0;
  logic [SW-1:0] GrayAll1 = '0, GrayAll2 = '0;
  logic          finish_clear = 1'b0;
  logic [GW-1:0] thresh;
  logic          thresh_vld, busy, ovr;

  int errors = 0;
  int checks = 0;
  int vld_cnt = 0;
  int ovr_cnt = 0;

  always #5 clock = ~clock;

  otsu_thresh dut (
    .clock        (clock),
    .rst          (rst),
    .dsp_vld      (dsp_vld),
    .N1           (N1),
    .N2           (N2),
    .GrayAll1     (GrayAll1),
    .GrayAll2     (GrayAll2),
    .finish_clear (finish_clear),
    .thresh       (thresh),
    .thresh_vld   (thresh_vld),
    .busy         (busy),
    .ovr          (ovr)
  );

  always @(negedge clock) if (thresh_vld === 1'b1) vld_cnt++;

  initial begin
    #5ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse(input int a1, input int a2, input int s1, input int s2, output logic ov);
    @(negedge clock);
    N1 = NW'(a1);
    N2 = NW'(a2);
    GrayAll1 = SW'(s1);
    GrayAll2 = SW'(s2);
    dsp_vld = 1'b1;
    #1 ov = ovr;
    @(negedge clock);
    dsp_vld = 1'b0;
  endtask

  // Two-level histogram: ca pixels at gray ga, cb pixels at gray gb
  task automatic run_frame(input int ga, input int ca, input int gb, input int cb, input int gap);
    int n1, n2, g1, g2;
    logic ov;
    for (int t = 0; t < 128; t++) begin
      n1 = ((ga <= t) ? ca : 0) + ((gb <= t) ? cb : 0);
      n2 = ((ga > t) ? ca : 0) + ((gb > t) ? cb : 0);
      g1 = ((ga <= t) ? ga * ca : 0) + ((gb <= t) ? gb * cb : 0);
      g2 = ((ga > t) ? ga * ca : 0) + ((gb > t) ? gb * cb : 0);
      pulse(n1, n2, g1, g2, ov);
      if (ov) ovr_cnt++;
      repeat (gap - 1) @(negedge clock);
    end
  endtask

  task automatic finish(input logic [GW-1:0] exp, input string tag);
    int base;
    bit got;
    base = vld_cnt;
    got = 1'b0;
    @(negedge clock);
    finish_clear = 1'b1;
    @(negedge clock);
    finish_clear = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clock);
      if (vld_cnt != base) got = 1'b1;
    end
    repeat (3) @(negedge clock);
    chk({tag, "_vld_seen"}, 64'(got), 64'd1);
    chk({tag, "_vld_count"}, 64'(vld_cnt - base), 64'd1);
    chk({tag, "_thresh"}, 64'(thresh), 64'(exp));
  endtask

  initial begin
    logic ov;
    int base;
    bit got;

    repeat (3) @(negedge clock);
    rst = 1'b0;
    @(negedge clock);
    chk("reset_thresh", 64'(thresh), 64'd0);
    chk("reset_thresh_vld", 64'(thresh_vld), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_ovr", 64'(ovr), 64'd0);

    // Single gray level: every candidate has an empty class
    ovr_cnt = 0;
    run_frame(20, 1000, 0, 0, 128);
    finish(7'd0, "single");
    chk("single_ovr_count", 64'(ovr_cnt), 64'd0);

    // Bimodal 500@10 / 500@100: variance ties across t=10..99
    ovr_cnt = 0;
    run_frame(10, 500, 100, 500, 32);
    finish(7'd10, "bimodal");
    chk("bimodal_ovr_count", 64'(ovr_cnt), 64'd0);

    // Unequal 300@40 / 100@80
    ovr_cnt = 0;
    run_frame(40, 300, 80, 100, 32);
    finish(7'd40, "unequal");
    chk("unequal_ovr_count", 64'(ovr_cnt), 64'd0);

    // Overrun: second pulse 5 cycles after the first is dropped
    pulse(10, 10, 10, 30, ov);
    chk("ovr_first_clean", 64'(ov), 64'd0);
    chk("busy_after_capture", 64'(busy), 64'd1);
    repeat (3) @(negedge clock);
    pulse(100, 100, 100, 12000, ov);
    chk("ovr_pulse", 64'(ov), 64'd1);
    repeat (30) @(negedge clock);
    pulse(10, 10, 10, 200, ov);
    chk("ovr_third_clean", 64'(ov), 64'd0);
    repeat (30) @(negedge clock);
    finish(7'd2, "overrun");

    // Early end: finish_clear while the t=1 candidate is in flight
    pulse(0, 50, 0, 100, ov);
    repeat (8) @(negedge clock);
    pulse(10, 10, 10, 100, ov);
    base = vld_cnt;
    repeat (2) @(negedge clock);
    finish_clear = 1'b1;
    @(negedge clock);
    finish_clear = 1'b0;
    repeat (10) @(negedge clock);
    chk("early_vld_held_off", 64'(vld_cnt - base), 64'd0);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clock);
      if (vld_cnt != base) got = 1'b1;
    end
    repeat (3) @(negedge clock);
    chk("early_vld_seen", 64'(got), 64'd1);
    chk("early_thresh", 64'(thresh), 64'd1);

    // Next frame: smaller variance at t=1 must still win after the clear
    pulse(0, 50, 0, 100, ov);
    repeat (8) @(negedge clock);
    pulse(10, 10, 10, 30, ov);
    repeat (30) @(negedge clock);
    finish(7'd1, "after_early");

    // Reset while the divider works on m2
    base = vld_cnt;
    pulse(500, 500, 5000, 50000, ov);
    repeat (10) @(negedge clock);
    rst = 1'b1;
    @(negedge clock);
    rst = 1'b0;
    chk("midrst_thresh", 64'(thresh), 64'd0);
    chk("midrst_thresh_vld", 64'(thresh_vld), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_ovr", 64'(ovr), 64'd0);
    chk("midrst_state", 64'(dut.state), 64'(IDLE));
    repeat (30) @(negedge clock);
    chk("midrst_no_vld", 64'(vld_cnt - base), 64'd0);

    // Exact class means at the divider for t=40 of the unequal histogram
    pulse(300, 100, 12000, 8000, ov);
    repeat (25) @(negedge clock);
    chk("div_m1", 64'(dut.m1_p0), 64'd40);
    chk("div_m2", 64'(dut.m2_p0), 64'd80);
    finish(7'd0, "div_frame");

    ovr_cnt = 0;
    run_frame(40, 300, 80, 100, 32);
    finish(7'd40, "post_reset");
    chk("post_reset_ovr_count", 64'(ovr_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
